// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryption, one round per clock, external round-key store indexed by rk_idx.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = T[2047 - 8 * a -: 8];
endmodule

module aes_shiftrows (
  input  logic [127:0] a,
  output logic [127:0] y
);
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign y[127 - 8 * (r + 4 * c) -: 8] = a[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
    end
  end
endmodule

module aes_mixcolumns (
  input  logic [127:0] a,
  output logic [127:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] b [4];
    for (genvar i = 0; i < 4; i++) begin : g_in
      assign b[i] = a[127 - 32 * c - 8 * i -: 8];
    end
    // 2*b[i] ^ 3*b[i+1] folded into a single xtime of their sum
    for (genvar i = 0; i < 4; i++) begin : g_out
      assign y[127 - 32 * c - 8 * i -: 8] = xt(b[i] ^ b[(i + 1) % 4]) ^ b[(i + 1) % 4] ^ b[(i + 2) % 4] ^ b[(i + 3) % 4];
    end
  end
endmodule

module aes_round_engine #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_block,
  output logic [KIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_block,
  output logic              busy
);
  if (!(NR == 10 || NR == 12 || NR == 14) || (1 << KIDX_W) <= NR) begin : g_bad_param
    $error("aes_round_engine: NR must be 10, 12 or 14 and 2**KIDX_W must exceed NR");
  end
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [KIDX_W-1:0] LAST = KIDX_W'(NR);
  state_t              state_q, state_d;
  logic [127:0]        blk_q, blk_d;
  logic [KIDX_W-1:0]   r_q, r_d;
  logic [127:0]        sb, sr, mc;
  logic                last;
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (.a(blk_q[127 - 8 * i -: 8]), .y(sb[127 - 8 * i -: 8]));
  end
  aes_shiftrows  u_shiftrows  (.a(sb), .y(sr));
  aes_mixcolumns u_mixcolumns (.a(sr), .y(mc));
  assign last      = r_q == LAST;
  assign out_block = blk_q;
  assign busy      = state_q != IDLE;
  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    r_d       = r_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = '0;
    case (state_q)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid) begin
          blk_d   = in_block ^ rk;
          r_d     = KIDX_W'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        rk_idx  = r_q;
        blk_d   = (last ? sr : mc) ^ rk;
        r_d     = last ? '0 : r_q + 1'b1;
        state_d = last ? DONE : ROUND;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = out_ready ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      blk_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      r_q     <= r_d;
    end
  end
endmodule

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative AES encryption datapath that generalises the single registered final round into a complete NR-round cipher. It runs one round per clock through SubBytes, ShiftRows, optional MixColumns and AddRoundKey. It requests each round key by index from an external key store. It sits between the HPS-facing block buffer and the ciphertext output path, with valid/ready handshakes on both sides.

## Interface
- NR, default 10: number of rounds. Legal values are 10, 12 and 14 (AES-128/192/256). Any other value is an elaboration error.
- KIDX_W, default 4: width of the round-key index. Must satisfy 2^KIDX_W > NR.

- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  in_block is presented.
- in_ready  output  1  engine can accept a block.
- in_block  input  128  plaintext; byte 0 = bits [127:120], column-major per FIPS-197.
- rk_idx  output  KIDX_W  index of the round key required this cycle.
- rk  input  128  round key for rk_idx; combinational, valid in the same cycle.
- out_valid  output  1  out_block holds a finished ciphertext.
- out_ready  input  1  downstream accepts out_block.
- out_block  output  128  ciphertext, same byte order as in_block.
- busy  output  1  high in every state except IDLE.

## Operation
- Reset is `reset`, synchronous and active-high, on clock `clk`.
- Registers: 128-bit data register D, round counter r (KIDX_W bits), FSM state {IDLE, ROUND, DONE}.
- Submodules: 16× sbox, shiftrow, and a mixcolumns instance (4 columns, GF(2^8) xtime, polynomial 0x11B).
- IDLE
  - in_ready = 1 and rk_idx = 0.
  - On in_valid: D <= in_block ^ rk, r <= 1, go to ROUND.
- ROUND
  - in_ready = 0 and rk_idx = r.
  - If r < NR: D <= MixColumns(ShiftRows(SubBytes(D))) ^ rk, r <= r+1.
  - If r == NR: D <= ShiftRows(SubBytes(D)) ^ rk (MixColumns skipped), go to DONE.
- DONE
  - out_valid = 1, in_ready = 0, rk_idx = 0.
  - D and out_block are held while out_ready = 0.
  - On out_ready: go to IDLE.
- out_block = D at all times. It is meaningful only while out_valid = 1.
- in_valid is ignored outside IDLE. The source must hold in_block until in_ready & in_valid.
- rk_idx is purely a function of state and r; it does not depend on rk.

## Timing
- Reset values:
  - State = IDLE, r = 0, D = 0.
  - out_valid = 0, out_block = 0, busy = 0, rk_idx = 0.
  - in_ready = 0 while reset is high, then 1 in the first cycle after reset deasserts.
- Accept edge E0 is the rising edge where in_valid & in_ready.
- Round k completes on edge E0+k. out_valid rises after edge E0+NR, i.e. NR cycles after acceptance.
- Minimum initiation interval is NR+2 cycles: accept, NR rounds, one DONE cycle with out_ready = 1.
- Earliest next accept is the edge after the DONE-handshake edge. There is no same-cycle IDLE bypass.
- Back-pressure: DONE may last any number of cycles. The output must not change and no key index advances.
- Reset asserted in ROUND or DONE aborts the block. The FSM returns to IDLE on that edge, no output handshake occurs, and D clears to 0.
- In IDLE, reset has priority over in_valid.
- rk must settle within the same cycle rk_idx is driven. The key-store path is combinational into the D register and is timing-critical with the sbox path.

## Test plan
- **FIPS-197 App. B (NR=10).** Stimulus: in_block 3243f6a8885a308d313198a2e0370734; bench supplies expansion of key 2b7e151628aed2a6abf7158809cf4f3c per rk_idx. Required: out_block 3925841d02dc09fbdc118597196a0b32, and out_valid high exactly 10 cycles after accept.
- **App. C.1/C.2/C.3 (NR=10, 12, 14 builds).** Stimulus: in_block 00112233445566778899aabbccddeeff with keys 000102…0f / …17 / …1f. Required outputs:
  - NR=10: 69c4e0d86a7b0430d8cdb78070b4c55a.
  - NR=12: dda97ca4864cdfe06eaf70a0ec0d7191.
  - NR=14: 8ea2b7ca516745bfeafc49904b496089.
- **Back-pressure.** Stimulus: hold out_ready = 0 for 7 cycles in DONE. Required: out_block is stable, rk_idx = 0, in_ready = 0, and a single handshake occurs on release.
- **Busy-ignore.** Stimulus: pulse in_valid with a different block mid-ROUND. Required: no effect on the result, and the block is not accepted until IDLE.
- **Reset mid-round.** Stimulus: assert reset at round 5. Required: out_valid never rises for that block, D = 0, and the next block encrypts correctly.
- **Back-to-back throughput.** Stimulus: out_ready = 1 and in_valid held with 4 consecutive vectors. Required: 4 correct outputs with accepts spaced exactly NR+2 cycles apart.
